uart_tx_arbiter: RTL and testbench

Shares one UART transmitter byte port between NUM_REQ independent message sources, such as a button-triggered banner, an RX echo path and a status reporter.
- Arbitration is round-robin at packet granularity.
- A granted requester keeps the transmitter until its byte flagged last has been accepted, so packets never interleave on the wire.
- Sits between the message sources and the UART TX serializer, which has a valid/ready byte interface.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Purpose:      shared types and constants for the UART transmit path.
// Latency:      n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    localparam int CLK_HZ       = 27000000;
    localparam int BAUD         = 115200;
    localparam int DELAY_FRAMES = 234;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_t;

    typedef logic [7:0] uart_byte_t;

    // Index reached by stepping 'offset' positions past 'base' in a ring of n.
    function automatic int rrIndex(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose:      combinational round-robin picker, first request after lastGrant wins.
// Latency:      purely combinational.
// Backpressure: none; caller decides when to register the pick.
//
// Ports:
//   reqVec    - request bits, one per requester
//   lastGrant - previous winner; the search starts one position after it
//   grantIdx  - winning index (equals lastGrant when nothing is found)
//   found     - at least one request was asserted
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [ID_W-1:0]    lastGrant,
    output logic [ID_W-1:0]    grantIdx,
    output logic               found
);

    logic [ID_W-1:0] candIdx;

    // Offsets run 1..NUM_REQ so lastGrant itself is checked last; a lone
    // requester can therefore win again on consecutive packets.
    always_comb begin
        grantIdx = lastGrant;
        found    = 1'b0;
        candIdx  = lastGrant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candIdx = ID_W'(rrIndex(int'(lastGrant), k, NUM_REQ));
            if (!found && reqVec[candIdx]) begin
                found    = 1'b1;
                grantIdx = candIdx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose:      packet-granular round-robin share of one UART TX byte port.
// Latency:      1 arbitration cycle, then 1 cycle from byte accept to tx_valid.
// Backpressure: granted req_ready follows the output slot (free or draining).
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   req_valid/req_data/req_last/req_ready - per-requester byte streams
//   tx_valid/tx_data/tx_ready             - registered byte slot to serializer
//   grant_id      - current or most recent winner (round-robin pointer)
//   busy          - a packet currently owns the transmitter
//   timeout_pulse - one cycle on forced release of a stalled grant
//
// Optional: define UART_ARB_TIMEOUT_EN to release a grant whose owner has
// been idle for TIMEOUT_CYCLES cycles mid-packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 27000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output uart_byte_t           tx_data,
    input  logic                 tx_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_pulse
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_badNumReq
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_t      stateQ;
    arb_state_t      stateNext;
    logic [ID_W-1:0] grantQ;
    logic [ID_W-1:0] grantNext;
    logic [ID_W-1:0] pickIdx;
    logic            pickFound;
    logic            slotFree;
    logic            grantValid;
    logic            grantLast;
    logic            handshake;
    logic            timeoutHit;
    uart_byte_t      reqBytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign reqBytes[i] = req_data[8*i +: 8];
    end

    // The slot can accept a byte when empty or when its byte leaves this cycle.
    assign slotFree   = !tx_valid || tx_ready;
    assign grantValid = req_valid[grantQ];
    assign grantLast  = req_last[grantQ];
    assign handshake  = (stateQ == ARB_LOCK) && grantValid && slotFree;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .reqVec    (req_valid),
        .lastGrant (grantQ),
        .grantIdx  (pickIdx),
        .found     (pickFound)
    );

    always_comb begin
        stateNext = stateQ;
        grantNext = grantQ;
        req_ready = '0;
        case (stateQ)
            ARB_IDLE: begin
                // Arbitration cycle: nobody is offered ready here.
                if (pickFound) begin
                    stateNext = ARB_LOCK;
                    grantNext = pickIdx;
                end
            end
            ARB_LOCK: begin
                req_ready[grantQ] = slotFree;
                if (handshake && grantLast) begin
                    stateNext = ARB_IDLE;
                end else if (timeoutHit) begin
                    // grantQ stays on the stalled owner, so the next search
                    // naturally starts just past it.
                    stateNext = ARB_IDLE;
                end
            end
            default: stateNext = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= ARB_IDLE;
            grantQ   <= ID_W'(NUM_REQ - 1);
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            stateQ <= stateNext;
            grantQ <= grantNext;
            if (handshake) begin
                tx_valid <= 1'b1;
                tx_data  <= reqBytes[grantQ];
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idleCnt;
    logic             timeoutPulseQ;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of the owner.
    assign timeoutHit = (stateQ == ARB_LOCK) && !grantValid &&
                        (idleCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idleCnt       <= '0;
            timeoutPulseQ <= 1'b0;
        end else begin
            timeoutPulseQ <= timeoutHit;
            if (stateQ != ARB_LOCK || handshake || timeoutHit) begin
                idleCnt <= '0;
            end else if (!grantValid) begin
                idleCnt <= idleCnt + CNT_W'(1);
            end
        end
    end

    assign timeout_pulse = timeoutPulseQ;
`else
    assign timeoutHit    = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    assign grant_id = grantQ;
    assign busy     = (stateQ == ARB_LOCK);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose:      directed bench for uart_tx_arbiter with 3 requesters.
// Latency:      n/a.
// Backpressure: tx_ready driven always-on, 1-on/3-off, or held low.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TB_TO = 20;
`else
    localparam int TB_TO = 27000000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_pulse;

    uart_tx_arbiter #(
        .NUM_REQ        (3),
        .ID_W           (2),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    // Source byte queues: bit 8 = last flag, bits 7:0 = data.
    logic [8:0] srcQ [3][$];
    int         srcLog [$];
    logic [7:0] txLog [$];
    int         readyMode;
    int         rdyCnt;
    int         viol;
    int         pulses;
    int         errors;
    int         checks;

    // Source/sink models: log handshakes at the edge, then re-drive 1 ns later.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && req_valid[i] && req_ready[i]) begin
                srcLog.push_back(i);
                void'(srcQ[i].pop_front());
            end
        end
        if (!rst && tx_valid && tx_ready) txLog.push_back(tx_data);
        if (!rst && (|req_ready) && !(!tx_valid || tx_ready)) viol++;
        if (!rst && timeout_pulse) pulses++;
        #1;
        rdyCnt++;
        tx_ready = (readyMode == 0) ? 1'b1 :
                   (readyMode == 1) ? (rdyCnt % 4 == 0) : 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (srcQ[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = srcQ[i][0][8];
                req_data[8*i +: 8]   = srcQ[i][0][7:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[8*i +: 8]   = 8'h00;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitDrained(input int maxCyc, input string tag);
        logic done;
        done = 1'b0;
        for (int c = 0; c < maxCyc && !done; c++) begin
            tick();
            if (srcQ[0].size() == 0 && srcQ[1].size() == 0 &&
                srcQ[2].size() == 0 && !tx_valid && !busy) done = 1'b1;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic clearLogs();
        srcLog.delete();
        txLog.delete();
    endtask

    logic [7:0] expTx  [$];
    int         expSrc [$];
    int         cnt    [3];
    logic       seen;

    initial begin
        errors = 0; checks = 0; viol = 0; pulses = 0; rdyCnt = 0;
        readyMode = 0;
        rst = 1'b1; tx_ready = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_tx_valid",  {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data",   {24'd0, tx_data}, 32'd0);
        chk("rst_req_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_grant_id",  {30'd0, grant_id}, 32'd2);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_timeout",   {31'd0, timeout_pulse}, 32'd0);

        // "Hi" from requester 1 with tx_ready high
        rst = 1'b0;
        tick();
        srcQ[1].push_back({1'b0, 8'h48});
        srcQ[1].push_back({1'b1, 8'h69});
        tick();
        chk("hi_arb_grant",   {30'd0, grant_id}, 32'd2);
        chk("hi_arb_busy",    {31'd0, busy}, 32'd0);
        chk("hi_arb_ready",   {29'd0, req_ready}, 32'd0);
        tick();
        chk("hi_grant",       {30'd0, grant_id}, 32'd1);
        chk("hi_busy",        {31'd0, busy}, 32'd1);
        chk("hi_ready",       {29'd0, req_ready}, 32'b010);
        tick();
        chk("hi_b0_valid",    {31'd0, tx_valid}, 32'd1);
        chk("hi_b0_data",     {24'd0, tx_data}, 32'h48);
        tick();
        chk("hi_b1_valid",    {31'd0, tx_valid}, 32'd1);
        chk("hi_b1_data",     {24'd0, tx_data}, 32'h69);
        chk("hi_busy_after",  {31'd0, busy}, 32'd0);
        tick();
        chk("hi_drained",     {31'd0, tx_valid}, 32'd0);
        chk("hi_ptr_kept",    {30'd0, grant_id}, 32'd1);

        // Simultaneous 3-byte packets from 0 and 2 after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clearLogs();
        for (int b = 0; b < 3; b++) begin
            srcQ[0].push_back({(b == 2), 8'hA0 + 8'(b)});
            srcQ[2].push_back({(b == 2), 8'hC0 + 8'(b)});
        end
        waitDrained(60, "sim_wait");
        expTx = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
        expSrc = '{0, 0, 0, 2, 2, 2};
        chk("sim_tx_count", txLog.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("sim_tx%0d", k), {24'd0, txLog[k]}, {24'd0, expTx[k]});
            chk($sformatf("sim_src%0d", k), srcLog[k], expSrc[k]);
        end

        // 12-byte packet with tx_ready 1-on/3-off
        readyMode = 1;
        clearLogs();
        viol = 0;
        for (int b = 0; b < 12; b++) srcQ[1].push_back({(b == 11), 8'h10 + 8'(b)});
        waitDrained(200, "slow_wait");
        chk("slow_count", txLog.size(), 32'd12);
        for (int k = 0; k < 12; k++)
            chk($sformatf("slow_tx%0d", k), {24'd0, txLog[k]}, 32'h10 + k);
        chk("slow_ready_only_when_free", viol, 32'd0);
        readyMode = 0;

        // Owner stalls mid-packet while requester 0 waits
        clearLogs();
        pulses = 0;
        srcQ[2].push_back({1'b0, 8'h30});
        srcQ[0].push_back({1'b1, 8'h50});
        repeat (50) tick();
`ifdef UART_ARB_TIMEOUT_EN
        chk("stall_pulses",    pulses, 32'd1);
        chk("stall_src_count", srcLog.size(), 32'd2);
        chk("stall_src1",      srcLog[1], 32'd0);
`else
        chk("stall_busy",      {31'd0, busy}, 32'd1);
        chk("stall_grant",     {30'd0, grant_id}, 32'd2);
        chk("stall_r0_ready",  {31'd0, req_ready[0]}, 32'd0);
        chk("stall_src_count", srcLog.size(), 32'd1);
        chk("stall_pulses",    pulses, 32'd0);
`endif
        srcQ[2].push_back({1'b1, 8'h31});
        waitDrained(40, "stall_wait");
`ifdef UART_ARB_TIMEOUT_EN
        expTx = '{8'h30, 8'h50, 8'h31};
        expSrc = '{2, 0, 2};
`else
        expTx = '{8'h30, 8'h31, 8'h50};
        expSrc = '{2, 2, 0};
`endif
        chk("stall_tx_count", txLog.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall_tx%0d", k), {24'd0, txLog[k]}, {24'd0, expTx[k]});
            chk($sformatf("stall_src%0d", k), srcLog[k], expSrc[k]);
        end

        // Reset while a byte is held in the slot
        readyMode = 2;
        srcQ[1].push_back({1'b0, 8'h70});
        srcQ[1].push_back({1'b0, 8'h71});
        srcQ[1].push_back({1'b1, 8'h72});
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (tx_valid) seen = 1'b1;
        end
        chk("rstmid_loaded", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        srcQ[1].delete();
        tick();
        chk("rstmid_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rstmid_busy",     {31'd0, busy}, 32'd0);
        chk("rstmid_grant",    {30'd0, grant_id}, 32'd2);
        rst = 1'b0;
        readyMode = 0;
        clearLogs();
        srcQ[0].push_back({1'b1, 8'h80});
        srcQ[1].push_back({1'b1, 8'h81});
        waitDrained(20, "rstmid_wait");
        chk("rstmid_src_count", srcLog.size(), 32'd2);
        chk("rstmid_first_src", srcLog[0], 32'd0);
        chk("rstmid_first_tx",  {24'd0, txLog[0]}, 32'h80);

        // 30 single-byte packets, all three requesters busy
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clearLogs();
        for (int n = 0; n < 10; n++)
            for (int i = 0; i < 3; i++)
                srcQ[i].push_back({1'b1, 8'(i * 16 + n)});
        waitDrained(200, "rr_wait");
        chk("rr_count", srcLog.size(), 32'd30);
        cnt = '{0, 0, 0};
        for (int k = 0; k < 30; k++) begin
            chk($sformatf("rr_seq%0d", k), srcLog[k], k % 3);
            if (srcLog[k] >= 0 && srcLog[k] < 3) cnt[srcLog[k]]++;
        end
        for (int i = 0; i < 3; i++) chk($sformatf("rr_cnt%0d", i), cnt[i], 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
